// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the SPI shadow-to-active load scheduler.
package load_scheduler_pkg;

    // Default width of the frames-since-load counter.
    localparam int unsigned LS_FCW_DEFAULT = 8;

    // Edge flags derived from a registered previous level and the current level.
    typedef struct packed {
        logic fall;
        logic rise;
    } edge_t;

    // Detect falling and rising transitions between two consecutive samples.
    function automatic edge_t detect_edges(input logic prev, input logic cur);
        edge_t e;
        e.fall = prev & ~cur;
        e.rise = ~prev & cur;
        return e;
    endfunction

endpackage

// File: rtl/load_scheduler_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pin inputs.
// RESET_VAL sets the level both flops take during reset, so an idle-high
// pin (such as an active-low chip select) does not look like an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage metastability filter on the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/load_scheduler.sv
// Holds a completed SPI transaction until vertical blanking, then issues a
// single-cycle en_load commit pulse so shadow registers never change
// mid-frame. Also counts vblank edges since the last commit.
module load_scheduler
    import load_scheduler_pkg::*;
#(
    parameter int unsigned FCW = LS_FCW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cs_in,
    input  logic           vblank_in,
    output logic           en_load,
    output logic           spi_busy_out,
    output logic           load_pending_out,
    output logic           overrun_out,
    output logic [FCW-1:0] frames_since_load_out
);

    // State encodings stay local to this block.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_PENDING = 2'd2,
        ST_LOAD    = 2'd3
    } state_e;

    localparam logic [FCW-1:0] CNT_MAX = {FCW{1'b1}};
    localparam logic [FCW-1:0] CNT_ONE = FCW'(1'b1);

    state_e         state_q;
    state_e         state_d;
    logic           cs_s2;
    logic           cs_prev_q;
    logic           vblank_prev_q;
    edge_t          cs_edge_s;
    logic           vb_rise_s;
    logic           en_load_q;
    logic           busy_q;
    logic           pending_q;
    logic           overrun_q;
    logic           overrun_d;
    logic [FCW-1:0] cnt_q;
    logic [FCW-1:0] cnt_d;

    // Chip select idles high, so the synchronizer resets to 1.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cs_in),
        .q_o   (cs_s2)
    );

    // Previous-level registers for chip-select and vblank edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev_q     <= 1'b1;
            vblank_prev_q <= 1'b0;
        end else begin
            cs_prev_q     <= cs_s2;
            vblank_prev_q <= vblank_in;
        end
    end

    // Edge strobes for the FSM and frame counter.
    always_comb begin
        cs_edge_s = detect_edges(cs_prev_q, cs_s2);
        vb_rise_s = vblank_in & ~vblank_prev_q;
    end

    // Transaction tracking: a new cs fall always wins over a pending commit,
    // but once LOAD is entered the commit is never cancelled.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_edge_s.fall) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (cs_edge_s.rise) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_PENDING: begin
                if (cs_edge_s.fall) begin
                    state_d   = ST_XFER;
                    overrun_d = 1'b1;
                end else if (vblank_in) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_LOAD: begin
                if (cs_edge_s.fall) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame counter: cleared on the edge that raises en_load (clear beats a
    // simultaneous vblank rise), otherwise counts vblank rises and saturates.
    always_comb begin
        if (state_d == ST_LOAD) begin
            cnt_d = {FCW{1'b0}};
        end else if (vb_rise_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, registered state-decoded outputs, counter and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_load_q <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= {FCW{1'b0}};
        end else begin
            state_q   <= state_d;
            en_load_q <= (state_d == ST_LOAD);
            busy_q    <= (state_d == ST_XFER);
            pending_q <= (state_d == ST_PENDING);
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign en_load               = en_load_q;
    assign spi_busy_out          = busy_q;
    assign load_pending_out      = pending_q;
    assign overrun_out           = overrun_q;
    assign frames_since_load_out = cnt_q;

endmodule

// File: tb/tb_load_scheduler.sv
// Directed self-checking bench for load_scheduler (FCW=8 and FCW=4 copies
// driven by the same stimulus). Inputs change and outputs are sampled on the
// falling clock edge; each step() advances past one rising edge.
module tb_load_scheduler;

    logic       clk;
    logic       rst_n;
    logic       cs_in;
    logic       vblank_in;

    logic       en_load;
    logic       spi_busy_out;
    logic       load_pending_out;
    logic       overrun_out;
    logic [7:0] frames_since_load_out;

    logic       en_load4;
    logic       spi_busy_out4;
    logic       load_pending_out4;
    logic       overrun_out4;
    logic [3:0] frames_since_load_out4;

    int n_checks;
    int n_fail;
    int en_cnt;
    int e0;

    load_scheduler #(.FCW(8)) u_dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cs_in                 (cs_in),
        .vblank_in             (vblank_in),
        .en_load               (en_load),
        .spi_busy_out          (spi_busy_out),
        .load_pending_out      (load_pending_out),
        .overrun_out           (overrun_out),
        .frames_since_load_out (frames_since_load_out)
    );

    load_scheduler #(.FCW(4)) u_dut4 (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cs_in                 (cs_in),
        .vblank_in             (vblank_in),
        .en_load               (en_load4),
        .spi_busy_out          (spi_busy_out4),
        .load_pending_out      (load_pending_out4),
        .overrun_out           (overrun_out4),
        .frames_since_load_out (frames_since_load_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commit pulses of the FCW=8 instance.
    always @(negedge clk) begin
        if (en_load) en_cnt <= en_cnt + 1;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        en_cnt    = 0;
        rst_n     = 1'b0;
        cs_in     = 1'b1;
        vblank_in = 1'b0;

        // Reset state
        step(3);
        check_eq("rst_en",      32'(en_load),               32'd0);
        check_eq("rst_busy",    32'(spi_busy_out),          32'd0);
        check_eq("rst_pend",    32'(load_pending_out),      32'd0);
        check_eq("rst_ovr",     32'(overrun_out),           32'd0);
        check_eq("rst_frames",  32'(frames_since_load_out), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("idle_en",   32'(en_load),          32'd0);
            check_eq("idle_busy", 32'(spi_busy_out),     32'd0);
            check_eq("idle_pend", 32'(load_pending_out), 32'd0);
        end
        check_eq("idle_frames", 32'(frames_since_load_out), 32'd0);
        check_eq("idle_ovr",    32'(overrun_out),           32'd0);

        // Transaction during active video, commit at vblank
        cs_in = 1'b0;
        step(1); check_eq("t2_busy_e0", 32'(spi_busy_out), 32'd0);
        step(1); check_eq("t2_busy_e1", 32'(spi_busy_out), 32'd0);
        step(1); check_eq("t2_busy_e2", 32'(spi_busy_out), 32'd1);
        step(17);
        cs_in = 1'b1;
        step(2);
        check_eq("t2_pend_e1", 32'(load_pending_out), 32'd0);
        check_eq("t2_busy_r1", 32'(spi_busy_out),     32'd1);
        step(1);
        check_eq("t2_pend_e2", 32'(load_pending_out), 32'd1);
        check_eq("t2_busy_r2", 32'(spi_busy_out),     32'd0);
        e0 = en_cnt;
        step(50);
        check_eq("t2_pend_hold", 32'(load_pending_out), 32'd1);
        check_eq("t2_no_early",  32'(en_cnt - e0),      32'd0);
        vblank_in = 1'b1;
        step(1);
        check_eq("t2_en_hi",     32'(en_load),               32'd1);
        check_eq("t2_pend_lo",   32'(load_pending_out),      32'd0);
        check_eq("t2_frames_p",  32'(frames_since_load_out), 32'd0);
        step(1);
        check_eq("t2_en_lo",     32'(en_load),               32'd0);
        check_eq("t2_frames",    32'(frames_since_load_out), 32'd0);
        check_eq("t2_one_pulse", 32'(en_cnt - e0),           32'd1);

        // Transaction completing with vblank already high
        cs_in = 1'b0;
        step(5);
        check_eq("t3_busy", 32'(spi_busy_out), 32'd1);
        e0 = en_cnt;
        cs_in = 1'b1;
        step(1); check_eq("t3_en_e0", 32'(en_load), 32'd0);
        step(1); check_eq("t3_en_e1", 32'(en_load), 32'd0);
        step(1);
        check_eq("t3_en_e2",   32'(en_load),          32'd0);
        check_eq("t3_pend_e2", 32'(load_pending_out), 32'd1);
        step(1);
        check_eq("t3_en_e3",   32'(en_load),          32'd1);
        check_eq("t3_pend_e3", 32'(load_pending_out), 32'd0);
        step(1); check_eq("t3_en_e4", 32'(en_load), 32'd0);
        step(10);
        check_eq("t3_one_pulse", 32'(en_cnt - e0), 32'd1);

        // Pending commit superseded before vblank
        vblank_in = 1'b0;
        step(2);
        cs_in = 1'b0; step(5);
        cs_in = 1'b1; step(3);
        check_eq("t4_pend1", 32'(load_pending_out), 32'd1);
        step(5);
        e0 = en_cnt;
        cs_in = 1'b0;
        step(2);
        check_eq("t4_ovr_e1",  32'(overrun_out),      32'd0);
        check_eq("t4_pend_e1", 32'(load_pending_out), 32'd1);
        step(1);
        check_eq("t4_ovr_e2",  32'(overrun_out),      32'd1);
        check_eq("t4_busy_e2", 32'(spi_busy_out),     32'd1);
        check_eq("t4_pend_e2", 32'(load_pending_out), 32'd0);
        step(2);
        cs_in = 1'b1; step(3);
        check_eq("t4_pend2",    32'(load_pending_out), 32'd1);
        check_eq("t4_no_early", 32'(en_cnt - e0),      32'd0);
        vblank_in = 1'b1;
        step(1); check_eq("t4_en_hi", 32'(en_load), 32'd1);
        step(1); check_eq("t4_en_lo", 32'(en_load), 32'd0);
        step(5);
        check_eq("t4_one_pulse", 32'(en_cnt - e0),  32'd1);
        check_eq("t4_ovr_stick", 32'(overrun_out), 32'd1);

        // Frame counter saturation (FCW=4) and clear-beats-rise
        e0 = en_cnt;
        for (int i = 0; i < 20; i++) begin
            vblank_in = 1'b0; step(1);
            vblank_in = 1'b1; step(1);
        end
        check_eq("t5_sat4",   32'(frames_since_load_out4), 32'd15);
        check_eq("t5_cnt8",   32'(frames_since_load_out),  32'd20);
        check_eq("t5_no_en",  32'(en_cnt - e0),            32'd0);
        vblank_in = 1'b0;
        cs_in = 1'b0; step(4);
        cs_in = 1'b1; step(3);
        check_eq("t5_pend",   32'(load_pending_out),       32'd1);
        check_eq("t5_hold4",  32'(frames_since_load_out4), 32'd15);
        vblank_in = 1'b1;
        step(1);
        check_eq("t5_en4",    32'(en_load4),               32'd1);
        check_eq("t5_clr4",   32'(frames_since_load_out4), 32'd0);
        check_eq("t5_clr8",   32'(frames_since_load_out),  32'd0);
        step(1);
        check_eq("t5_clr4_b", 32'(frames_since_load_out4), 32'd0);

        // Reset while pending: commit is dropped
        vblank_in = 1'b0; step(2);
        cs_in = 1'b0; step(4);
        cs_in = 1'b1; step(3);
        check_eq("t6_pend", 32'(load_pending_out), 32'd1);
        e0 = en_cnt;
        vblank_in = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_pend_rst", 32'(load_pending_out), 32'd0);
        step(3);
        check_eq("t6_en_rst", 32'(en_load), 32'd0);
        rst_n = 1'b1;
        step(10);
        check_eq("t6_no_en",  32'(en_cnt - e0),            32'd0);
        check_eq("t6_pend_after", 32'(load_pending_out),   32'd0);
        check_eq("t6_busy_after", 32'(spi_busy_out),       32'd0);
        check_eq("t6_ovr_clr",    32'(overrun_out),        32'd0);
        check_eq("t6_frames",     32'(frames_since_load_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
